// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - class encodings and packed entry layout shared by the dispatch queue
package dispatch_pkg;

   typedef enum logic [1:0] {
      CLS_FXU = 2'd0,
      CLS_LSU = 2'd1,
      CLS_BR  = 2'd2,
      CLS_NOP = 2'd3
   } op_class_t;

   localparam int OPCODE_W = 4;
   localparam int IMM_W    = 8;
   localparam int CLASS_W  = 2;

   localparam int DEF_TAG_W  = 4;
   localparam int DEF_DATA_W = 16;

   // Entry layout, MSB first:
   // {opcode, imm, class, rob_idx, a_valid, a_tag, a_value, b_valid, b_tag, b_value}
   // Offsets are LSB positions; they depend on the tag and data widths of the instance.
   function automatic int off_b_value();
      return 0;
   endfunction

   function automatic int off_b_tag(input int data_w);
      return data_w;
   endfunction

   function automatic int off_b_valid(input int tag_w, input int data_w);
      return data_w + tag_w;
   endfunction

   function automatic int off_a_value(input int tag_w, input int data_w);
      return data_w + tag_w + 1;
   endfunction

   function automatic int off_a_tag(input int tag_w, input int data_w);
      return 2 * data_w + tag_w + 1;
   endfunction

   function automatic int off_a_valid(input int tag_w, input int data_w);
      return 2 * data_w + 2 * tag_w + 1;
   endfunction

   function automatic int off_rob(input int tag_w, input int data_w);
      return 2 * data_w + 2 * tag_w + 2;
   endfunction

   function automatic int off_class(input int tag_w, input int data_w);
      return 2 * data_w + 3 * tag_w + 2;
   endfunction

   function automatic int off_imm(input int tag_w, input int data_w);
      return off_class(tag_w, data_w) + CLASS_W;
   endfunction

   function automatic int off_opcode(input int tag_w, input int data_w);
      return off_imm(tag_w, data_w) + IMM_W;
   endfunction

   function automatic int entry_w(input int tag_w, input int data_w);
      return off_opcode(tag_w, data_w) + OPCODE_W;
   endfunction

   localparam int ENTRY_W = entry_w(DEF_TAG_W, DEF_DATA_W);

endpackage

// File: rtl/operand_wakeup.sv
// rtl/operand_wakeup.sv - tag match of one source operand against the result broadcast lanes
module operand_wakeup
#(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 16,
   parameter int NUM_BC = 2
) (
   input  logic                     valid,
   input  logic [TAG_W-1:0]         tag,
   input  logic [DATA_W-1:0]        value,
   input  logic [NUM_BC-1:0]        bc_valid,
   input  logic [NUM_BC*TAG_W-1:0]  bc_tag_flat,
   input  logic [NUM_BC*DATA_W-1:0] bc_value_flat,
   output logic                     woke_valid,
   output logic [DATA_W-1:0]        woke_value
);

   // capture a matching broadcast into a waiting operand; scanning downward lets the lowest lane win
   always_comb begin
      woke_valid = valid;
      woke_value = value;
      if (!valid) begin
         for (int l = NUM_BC - 1; l >= 0; l--) begin
            if (bc_valid[l] && (bc_tag_flat[l*TAG_W +: TAG_W] == tag)) begin
               woke_valid = 1'b1;
               woke_value = bc_value_flat[l*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - in-order circular dispatch queue feeding FXU, LSU and BR channels
module dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 16,
   parameter int NUM_FXU = 2,
   parameter int DATA_W  = 16,
   parameter int TAG_W   = 4,
   parameter int NUM_BC  = 2,
   localparam int ENT_W  = entry_w(TAG_W, DATA_W),
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int FS_W   = $clog2(WIDTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          enq_valid,
   input  logic [WIDTH*ENT_W-1:0]    enq_entry_flat,
   output logic [FS_W-1:0]           free_slots,
   input  logic [NUM_BC-1:0]         bc_valid,
   input  logic [NUM_BC*TAG_W-1:0]   bc_tag_flat,
   input  logic [NUM_BC*DATA_W-1:0]  bc_value_flat,
   input  logic                      flush,
   input  logic [NUM_FXU-1:0]        fxu_ready,
   input  logic                      lsu_ready,
   input  logic                      br_ready,
   output logic [NUM_FXU-1:0]        fxu_out_valid,
   output logic [NUM_FXU*ENT_W-1:0]  fxu_out_flat,
   output logic                      lsu_out_valid,
   output logic [ENT_W-1:0]          lsu_out_flat,
   output logic                      br_out_valid,
   output logic [ENT_W-1:0]          br_out_flat,
   output logic [CNT_W-1:0]          count
);

   localparam int OFF_BVAL = off_b_value();
   localparam int OFF_BT   = off_b_tag(DATA_W);
   localparam int OFF_BV   = off_b_valid(TAG_W, DATA_W);
   localparam int OFF_AVAL = off_a_value(TAG_W, DATA_W);
   localparam int OFF_AT   = off_a_tag(TAG_W, DATA_W);
   localparam int OFF_AV   = off_a_valid(TAG_W, DATA_W);
   localparam int OFF_CLS  = off_class(TAG_W, DATA_W);

   // queue state
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [DEPTH-1:0]  ent_valid;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;

   // stored entries with this cycle's broadcasts already folded in
   logic [DEPTH-1:0]  slot_av;
   logic [DEPTH-1:0]  slot_bv;
   logic [DATA_W-1:0] slot_aval [DEPTH];
   logic [DATA_W-1:0] slot_bval [DEPTH];
   logic [ENT_W-1:0]  slot_word [DEPTH];

   // incoming lanes with this cycle's broadcasts folded in
   logic [WIDTH-1:0]  lane_av;
   logic [WIDTH-1:0]  lane_bv;
   logic [DATA_W-1:0] lane_aval [WIDTH];
   logic [DATA_W-1:0] lane_bval [WIDTH];
   logic [ENT_W-1:0]  lane_word [WIDTH];

   logic [FS_W-1:0]   enq_k;
   logic              enq_accept;
   logic [FS_W-1:0]   d_cnt;

   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_BC(NUM_BC)) u_wake_a (
         .valid         (mem[g][OFF_AV]),
         .tag           (mem[g][OFF_AT +: TAG_W]),
         .value         (mem[g][OFF_AVAL +: DATA_W]),
         .bc_valid      (bc_valid),
         .bc_tag_flat   (bc_tag_flat),
         .bc_value_flat (bc_value_flat),
         .woke_valid    (slot_av[g]),
         .woke_value    (slot_aval[g])
      );
      operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_BC(NUM_BC)) u_wake_b (
         .valid         (mem[g][OFF_BV]),
         .tag           (mem[g][OFF_BT +: TAG_W]),
         .value         (mem[g][OFF_BVAL +: DATA_W]),
         .bc_valid      (bc_valid),
         .bc_tag_flat   (bc_tag_flat),
         .bc_value_flat (bc_value_flat),
         .woke_valid    (slot_bv[g]),
         .woke_value    (slot_bval[g])
      );
   end

   for (genvar j = 0; j < WIDTH; j++) begin : g_lane
      operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_BC(NUM_BC)) u_wake_a (
         .valid         (enq_entry_flat[j*ENT_W + OFF_AV]),
         .tag           (enq_entry_flat[j*ENT_W + OFF_AT +: TAG_W]),
         .value         (enq_entry_flat[j*ENT_W + OFF_AVAL +: DATA_W]),
         .bc_valid      (bc_valid),
         .bc_tag_flat   (bc_tag_flat),
         .bc_value_flat (bc_value_flat),
         .woke_valid    (lane_av[j]),
         .woke_value    (lane_aval[j])
      );
      operand_wakeup #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NUM_BC(NUM_BC)) u_wake_b (
         .valid         (enq_entry_flat[j*ENT_W + OFF_BV]),
         .tag           (enq_entry_flat[j*ENT_W + OFF_BT +: TAG_W]),
         .value         (enq_entry_flat[j*ENT_W + OFF_BVAL +: DATA_W]),
         .bc_valid      (bc_valid),
         .bc_tag_flat   (bc_tag_flat),
         .bc_value_flat (bc_value_flat),
         .woke_valid    (lane_bv[j]),
         .woke_value    (lane_bval[j])
      );
   end

   // merge woken operands back into full entry words for storage and dispatch bypass
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         slot_word[i]                       = mem[i];
         slot_word[i][OFF_AV]               = slot_av[i];
         slot_word[i][OFF_AVAL +: DATA_W]   = slot_aval[i];
         slot_word[i][OFF_BV]               = slot_bv[i];
         slot_word[i][OFF_BVAL +: DATA_W]   = slot_bval[i];
      end
      for (int j = 0; j < WIDTH; j++) begin
         lane_word[j]                       = enq_entry_flat[j*ENT_W +: ENT_W];
         lane_word[j][OFF_AV]               = lane_av[j];
         lane_word[j][OFF_AVAL +: DATA_W]   = lane_aval[j];
         lane_word[j][OFF_BV]               = lane_bv[j];
         lane_word[j][OFF_BVAL +: DATA_W]   = lane_bval[j];
      end
   end

   // room advertised to decode: never more than one full group
   always_comb begin
      if (DEPTH - int'(count) >= WIDTH)
         free_slots = FS_W'(WIDTH);
      else
         free_slots = FS_W'(DEPTH - int'(count));
   end

   // a group is taken whole or not at all; flush discards it
   always_comb begin
      enq_k      = FS_W'($countones(enq_valid));
      enq_accept = !flush && (enq_k != '0) && (enq_k <= free_slots);
   end

   // in-order scan of the oldest entries; the first entry without a free channel blocks all younger ones
   always_comb begin
      logic [PTR_W-1:0]   idx;
      logic               stop;
      logic               found;
      logic [NUM_FXU-1:0] fxu_used;
      logic               lsu_used;
      logic               br_used;

      fxu_out_valid = '0;
      fxu_out_flat  = '0;
      lsu_out_valid = 1'b0;
      lsu_out_flat  = '0;
      br_out_valid  = 1'b0;
      br_out_flat   = '0;
      d_cnt         = '0;
      idx           = '0;
      found         = 1'b0;
      fxu_used      = '0;
      lsu_used      = 1'b0;
      br_used       = 1'b0;
      stop          = flush;

      for (int i = 0; i < WIDTH; i++) begin
         idx = head + PTR_W'(i);
         if (!stop && (i < int'(count)) && ent_valid[idx]) begin
            case (op_class_t'(mem[idx][OFF_CLS +: CLASS_W]))
               CLS_FXU: begin
                  found = 1'b0;
                  for (int c = 0; c < NUM_FXU; c++) begin
                     if (!found && fxu_ready[c] && !fxu_used[c]) begin
                        found                          = 1'b1;
                        fxu_used[c]                    = 1'b1;
                        fxu_out_valid[c]               = 1'b1;
                        fxu_out_flat[c*ENT_W +: ENT_W] = slot_word[idx];
                     end
                  end
                  if (!found)
                     stop = 1'b1;
               end
               CLS_LSU: begin
                  if (lsu_ready && !lsu_used) begin
                     lsu_used      = 1'b1;
                     lsu_out_valid = 1'b1;
                     lsu_out_flat  = slot_word[idx];
                  end else begin
                     stop = 1'b1;
                  end
               end
               CLS_BR: begin
                  if (br_ready && !br_used) begin
                     br_used      = 1'b1;
                     br_out_valid = 1'b1;
                     br_out_flat  = slot_word[idx];
                  end else begin
                     stop = 1'b1;
                  end
               end
               default: begin
                  // NOP retires from the queue without occupying a channel
               end
            endcase
            if (!stop)
               d_cnt = d_cnt + FS_W'(1);
         end else begin
            stop = 1'b1;
         end
      end
   end

   // pointers, occupancy and entry-valid bits; flush clears everything at the edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else if (flush) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         ent_valid <= '0;
      end else begin
         head  <= head + PTR_W'(d_cnt);
         count <= count + (enq_accept ? CNT_W'(enq_k) : CNT_W'(0)) - CNT_W'(d_cnt);
         if (enq_accept)
            tail <= tail + PTR_W'(enq_k);
         for (int j = 0; j < WIDTH; j++) begin
            if (j < int'(d_cnt))
               ent_valid[head + PTR_W'(j)] <= 1'b0;
         end
         for (int j = 0; j < WIDTH; j++) begin
            if (enq_accept && enq_valid[j])
               ent_valid[tail + PTR_W'(j)] <= 1'b1;
         end
      end
   end

   // payload storage follows operand wakeups every cycle; accepted lanes land at the tail
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++)
         mem[i] <= slot_word[i];
      if (enq_accept) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (enq_valid[j])
               mem[tail + PTR_W'(j)] <= lane_word[j];
         end
      end
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// tb/tb_dispatch_queue.sv - scoreboard bench for dispatch_queue with directed vectors
module tb_dispatch_queue;

   localparam int W  = 4;
   localparam int D  = 16;
   localparam int NF = 2;
   localparam int DW = 16;
   localparam int TW = 4;
   localparam int NB = 2;
   localparam int EW = 60;

   localparam logic [1:0] FXU = 2'd0;
   localparam logic [1:0] LSU = 2'd1;
   localparam logic [1:0] BR  = 2'd2;
   localparam logic [1:0] NOP = 2'd3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [W-1:0]      enq_valid;
   logic [W*EW-1:0]   enq_entry_flat;
   logic [2:0]        free_slots;
   logic [NB-1:0]     bc_valid;
   logic [NB*TW-1:0]  bc_tag_flat;
   logic [NB*DW-1:0]  bc_value_flat;
   logic              flush;
   logic [NF-1:0]     fxu_ready;
   logic              lsu_ready;
   logic              br_ready;
   logic [NF-1:0]     fxu_out_valid;
   logic [NF*EW-1:0]  fxu_out_flat;
   logic              lsu_out_valid;
   logic [EW-1:0]     lsu_out_flat;
   logic              br_out_valid;
   logic [EW-1:0]     br_out_flat;
   logic [4:0]        count;

   typedef struct {
      int            cyc;
      int            ch;
      logic [EW-1:0] ent;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   dispatch_queue #(
      .WIDTH(W), .DEPTH(D), .NUM_FXU(NF), .DATA_W(DW), .TAG_W(TW), .NUM_BC(NB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enq_valid      (enq_valid),
      .enq_entry_flat (enq_entry_flat),
      .free_slots     (free_slots),
      .bc_valid       (bc_valid),
      .bc_tag_flat    (bc_tag_flat),
      .bc_value_flat  (bc_value_flat),
      .flush          (flush),
      .fxu_ready      (fxu_ready),
      .lsu_ready      (lsu_ready),
      .br_ready       (br_ready),
      .fxu_out_valid  (fxu_out_valid),
      .fxu_out_flat   (fxu_out_flat),
      .lsu_out_valid  (lsu_out_valid),
      .lsu_out_flat   (lsu_out_flat),
      .br_out_valid   (br_out_valid),
      .br_out_flat    (br_out_flat),
      .count          (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [EW-1:0] mk(input logic [3:0] op, input logic [7:0] imm,
                                        input logic [1:0] cls, input logic [3:0] rob,
                                        input logic av, input logic [3:0] at, input logic [15:0] aval,
                                        input logic bv, input logic [3:0] bt, input logic [15:0] bval);
      return {op, imm, cls, rob, av, at, aval, bv, bt, bval};
   endfunction

   function automatic logic [EW-1:0] ent(input logic [1:0] cls, input int s);
      return mk(4'(s), 8'(s), cls, 4'(s), 1'b1, 4'(s + 1), 16'(s * 3), 1'b1, 4'(s + 2), 16'(s + 100));
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push(input int c, input int ch, input logic [EW-1:0] e);
      sb.push_back('{c, ch, e});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int l, input logic [EW-1:0] e);
      enq_entry_flat[l*EW +: EW] = e;
   endtask

   task automatic set_bc(input int l, input logic v, input logic [3:0] t, input logic [15:0] val);
      bc_valid[l]                 = v;
      bc_tag_flat[l*TW +: TW]     = t;
      bc_value_flat[l*DW +: DW]   = val;
   endtask

   // monitor: every asserted channel pops the oldest expectation (channels checked fxu0, fxu1, lsu, br)
   logic          mv;
   logic [EW-1:0] md;
   exp_t          me;
   always @(negedge clk) begin
      if (!rst) begin
         for (int ch = 0; ch < 4; ch++) begin
            case (ch)
               0:       begin mv = fxu_out_valid[0]; md = fxu_out_flat[0 +: EW];  end
               1:       begin mv = fxu_out_valid[1]; md = fxu_out_flat[EW +: EW]; end
               2:       begin mv = lsu_out_valid;    md = lsu_out_flat;           end
               default: begin mv = br_out_valid;     md = br_out_flat;            end
            endcase
            if (mv) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_dispatch ch%0d cyc %0d: got %h expected none", ch, cyc, md);
               end else begin
                  me = sb.pop_front();
                  if (me.ch != ch || me.ent !== md || (me.cyc >= 0 && me.cyc != cyc)) begin
                     n_fail++;
                     $display("FAIL dispatch ch%0d cyc %0d: got %h expected ch%0d cyc %0d %h",
                              ch, cyc, md, me.ch, me.cyc, me.ent);
                  end
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int nxt;
      enq_valid      = '0;
      enq_entry_flat = '0;
      bc_valid       = '0;
      bc_tag_flat    = '0;
      bc_value_flat  = '0;
      flush          = 1'b0;
      fxu_ready      = '0;
      lsu_ready      = 1'b0;
      br_ready       = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset_count", 64'(count), 64'd0);
      chk("reset_free_slots", 64'(free_slots), 64'd4);
      chk("reset_out_valid", 64'({fxu_out_valid, lsu_out_valid, br_out_valid}), 64'd0);

      // four FXU, two channels: two now, two next cycle
      fxu_ready = 2'b11; lsu_ready = 1'b1; br_ready = 1'b1;
      c = cyc;
      for (int l = 0; l < 4; l++) set_lane(l, ent(FXU, 1 + l));
      enq_valid = 4'hf;
      push(c + 1, 0, ent(FXU, 1)); push(c + 1, 1, ent(FXU, 2));
      push(c + 2, 0, ent(FXU, 3)); push(c + 2, 1, ent(FXU, 4));
      tick(); enq_valid = '0;
      chk("fxu4_count_n1", 64'(count), 64'd4);
      tick();
      chk("fxu4_count_n2", 64'(count), 64'd2);
      tick();
      chk("fxu4_count_n3", 64'(count), 64'd0);

      // only channel 1 ready: FXU goes to the lowest ready channel
      fxu_ready = 2'b10;
      c = cyc;
      set_lane(0, ent(FXU, 5));
      enq_valid = 4'b0001;
      push(c + 1, 1, ent(FXU, 5));
      tick(); enq_valid = '0;
      tick();

      // FXU, BR, BR: second BR waits a cycle
      fxu_ready = 2'b11;
      c = cyc;
      set_lane(0, ent(FXU, 6)); set_lane(1, ent(BR, 7)); set_lane(2, ent(BR, 8));
      enq_valid = 4'b0111;
      push(c + 1, 0, ent(FXU, 6)); push(c + 1, 3, ent(BR, 7)); push(c + 2, 3, ent(BR, 8));
      tick(); enq_valid = '0;
      tick(); tick();

      // LSU, NOP, FXU, LSU: NOP retires silently, second LSU stalls behind the used channel
      c = cyc;
      set_lane(0, ent(LSU, 9)); set_lane(1, ent(NOP, 10)); set_lane(2, ent(FXU, 11)); set_lane(3, ent(LSU, 12));
      enq_valid = 4'hf;
      push(c + 1, 0, ent(FXU, 11)); push(c + 1, 2, ent(LSU, 9)); push(c + 2, 2, ent(LSU, 12));
      tick(); enq_valid = '0;
      tick(); tick();
      chk("nop_group_count", 64'(count), 64'd0);

      // same-cycle broadcast bypass on lane 1
      c = cyc;
      set_lane(0, mk(4'h1, 8'h21, FXU, 4'h1, 1'b0, 4'd5, 16'h0000, 1'b1, 4'd0, 16'h0042));
      enq_valid = 4'b0001;
      push(c + 1, 0, mk(4'h1, 8'h21, FXU, 4'h1, 1'b1, 4'd5, 16'h1234, 1'b1, 4'd0, 16'h0042));
      tick(); enq_valid = '0;
      set_bc(0, 1'b0, 4'd5, 16'h9999);
      set_bc(1, 1'b1, 4'd5, 16'h1234);
      tick(); bc_valid = '0;

      // two lanes match: lane 0 wins
      c = cyc;
      set_lane(0, mk(4'h2, 8'h22, FXU, 4'h2, 1'b0, 4'd3, 16'h0000, 1'b1, 4'd0, 16'h0001));
      enq_valid = 4'b0001;
      push(c + 1, 0, mk(4'h2, 8'h22, FXU, 4'h2, 1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd0, 16'h0001));
      tick(); enq_valid = '0;
      set_bc(0, 1'b1, 4'd3, 16'hBEEF);
      set_bc(1, 1'b1, 4'd3, 16'hCAFE);
      tick(); bc_valid = '0;

      // stored b operand captures a broadcast while the entry waits
      fxu_ready = 2'b00;
      c = cyc;
      set_lane(0, mk(4'h3, 8'h23, FXU, 4'h3, 1'b1, 4'd0, 16'h0003, 1'b0, 4'd9, 16'h0000));
      enq_valid = 4'b0001;
      push(c + 2, 0, mk(4'h3, 8'h23, FXU, 4'h3, 1'b1, 4'd0, 16'h0003, 1'b1, 4'd9, 16'h5555));
      tick(); enq_valid = '0;
      set_bc(0, 1'b1, 4'd9, 16'h5555);
      tick(); bc_valid = '0; fxu_ready = 2'b01;
      tick();

      // incoming a operand captures a broadcast in its enqueue cycle
      fxu_ready = 2'b00;
      c = cyc;
      set_lane(0, mk(4'h4, 8'h24, FXU, 4'h4, 1'b0, 4'd2, 16'h0000, 1'b1, 4'd0, 16'h0004));
      enq_valid = 4'b0001;
      set_bc(1, 1'b1, 4'd2, 16'h7777);
      push(c + 1, 0, mk(4'h4, 8'h24, FXU, 4'h4, 1'b1, 4'd2, 16'h7777, 1'b1, 4'd0, 16'h0004));
      tick(); enq_valid = '0; bc_valid = '0; fxu_ready = 2'b01;
      tick();
      chk("wakeup_count", 64'(count), 64'd0);

      // fill to DEPTH with no channel ready
      fxu_ready = 2'b00; lsu_ready = 1'b0; br_ready = 1'b0;
      for (int g = 0; g < 4; g++) begin
         for (int l = 0; l < 4; l++) set_lane(l, ent((4 * g + l < 2) ? FXU : LSU, 4 * g + l));
         enq_valid = 4'hf;
         tick();
      end
      enq_valid = '0;
      chk("full_count", 64'(count), 64'd16);
      chk("full_free_slots", 64'(free_slots), 64'd0);

      // 2-lane group into a full queue is dropped whole
      set_lane(0, ent(FXU, 200)); set_lane(1, ent(FXU, 201));
      enq_valid = 4'b0011;
      tick(); enq_valid = '0;
      chk("drop_count", 64'(count), 64'd16);

      // FXU, FXU, LSU dispatch together; the next LSU stalls
      fxu_ready = 2'b11; lsu_ready = 1'b1;
      c = cyc;
      push(c, 0, ent(FXU, 0)); push(c, 1, ent(FXU, 1)); push(c, 2, ent(LSU, 2));
      tick();
      fxu_ready = 2'b00; lsu_ready = 1'b0;
      chk("after3_free_slots", 64'(free_slots), 64'd3);
      chk("after3_count", 64'(count), 64'd13);

      // stream 40 more LSU entries through the wrap, checked in program order
      lsu_ready = 1'b1;
      for (int s = 3; s < 16; s++) push(-1, 2, ent(LSU, s));
      nxt = 16;
      for (int t = 0; t < 400 && (nxt < 56 || sb.size() != 0); t++) begin
         if (nxt < 56 && free_slots >= 3'd4) begin
            for (int l = 0; l < 4; l++) begin
               set_lane(l, ent(LSU, nxt + l));
               push(-1, 2, ent(LSU, nxt + l));
            end
            enq_valid = 4'hf;
            nxt += 4;
         end else begin
            enq_valid = '0;
         end
         tick();
      end
      enq_valid = '0;
      chk("stream_drained", 64'(sb.size()), 64'd0);
      chk("stream_count", 64'(count), 64'd0);

      // flush with 9 entries and an enqueue in flight
      fxu_ready = 2'b00; lsu_ready = 1'b0;
      for (int g = 0; g < 3; g++) begin
         for (int l = 0; l < 4; l++) set_lane(l, ent(FXU, 100 + 4 * g + l));
         enq_valid = (g == 2) ? 4'b0001 : 4'hf;
         tick();
      end
      enq_valid = '0;
      chk("preflush_count", 64'(count), 64'd9);
      fxu_ready = 2'b11; lsu_ready = 1'b1; br_ready = 1'b1;
      flush = 1'b1;
      for (int l = 0; l < 4; l++) set_lane(l, ent(FXU, 120 + l));
      enq_valid = 4'hf;
      #3;
      chk("flush_out_valid", 64'({fxu_out_valid, lsu_out_valid, br_out_valid}), 64'd0);
      tick();
      flush = 1'b0; enq_valid = '0;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_free_slots", 64'(free_slots), 64'd4);

      // reset while two entries are dispatching
      c = cyc;
      set_lane(0, ent(FXU, 60)); set_lane(1, ent(FXU, 61));
      enq_valid = 4'b0011;
      push(c + 1, 0, ent(FXU, 60)); push(c + 1, 1, ent(FXU, 61));
      tick(); enq_valid = '0;
      #6 rst = 1'b1;
      #1;
      chk("rst_out_valid", 64'({fxu_out_valid, lsu_out_valid, br_out_valid}), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("end_scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 4: decode lanes enqueued and maximum entries dispatched per cycle.
REQ-002 SHALL have parameter DEPTH, default 16: queue entries, power of two, at least WIDTH.
REQ-003 SHALL have parameter NUM_FXU, default 2: fixed-point dispatch channels.
REQ-004 SHALL have parameter DATA_W, default 16: operand width.
REQ-005 SHALL have parameter TAG_W, default 4: ROB index width.
REQ-006 SHALL have parameter NUM_BC, default 2: result broadcast lanes.
REQ-007 SHALL have port clk, input, 1: single clock; all state on posedge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port enq_valid, input, WIDTH: lane-valid bits; lane 0 is oldest; set bits contiguous from lane 0.
REQ-010 SHALL have port enq_entry_flat, input, WIDTH*ENTRY_W: per-lane packed entry {opcode 4, imm 8, class 2, rob_idx, a_valid, a_tag, a_value, b_valid, b_tag, b_value}.
REQ-011 SHALL have port free_slots, output, clog2(WIDTH+1): min(WIDTH, DEPTH-count).
REQ-012 SHALL have ports bc_valid (NUM_BC), bc_tag_flat (NUM_BC*TAG_W), bc_value_flat (NUM_BC*DATA_W), all inputs: result broadcasts.
REQ-013 SHALL have port flush, input, 1: discard all contents.
REQ-014 SHALL have ports fxu_ready (NUM_FXU), lsu_ready (1) and br_ready (1), all inputs: channel can accept this cycle.
REQ-015 SHALL have ports fxu_out_valid (NUM_FXU) and fxu_out_flat (NUM_FXU*ENTRY_W), both outputs.
REQ-016 SHALL have ports lsu_out_valid/lsu_out_flat and br_out_valid/br_out_flat, all outputs, 1 and ENTRY_W wide.
REQ-017 SHALL have port count, output, clog2(DEPTH+1): current occupancy.

Function
REQ-018 SHALL store entries in a circular buffer with head/tail pointers mod DEPTH; wrap SHALL preserve program order.
REQ-019 SHALL write an enqueue group of k=popcount(enq_valid) at tail when k<=free_slots; a group with k>free_slots SHALL be dropped whole.
REQ-020 SHALL make an entry enqueued at edge N dispatchable no earlier than cycle N+1.
REQ-021 SHALL scan the oldest min(WIDTH,count) entries in order; an entry dispatches only if every older scanned entry dispatches.
REQ-022 SHALL assign FXU-class entries to the lowest-index ready, unused fxu channel, and LSU-class/BR-class entries to their single channel if ready and unused.
REQ-023 SHALL stop the scan at the first entry lacking a channel; class NOP (3) SHALL retire with no output.
REQ-024 SHALL assert out_valid combinationally in the dispatch cycle; the channel captures the entry on that edge; head advances by d.
REQ-025 SHALL set count_next = count + k_accepted - d when enqueue and dispatch occur in the same cycle.
REQ-026 SHALL set a_valid and capture the value of a stored or incoming entry whose invalid operand tag matches a valid broadcast; same for b.
REQ-027 SHALL let the lowest broadcast lane win when several lanes match.
REQ-028 SHALL bypass same-cycle broadcast values into dispatched outputs.
REQ-029 SHALL, on flush, force all out_valid low that cycle, ignore enqueue, and clear head, tail and count at the edge.
REQ-030 SHALL hold all out_valid at 0 when empty, and drive free_slots to 0 when full.

Reset
REQ-031 SHALL, on rst, asynchronously zero head, tail, count, entry-valid bits and all out_valid; free_slots=min(WIDTH,DEPTH); payload storage not reset.

Structure
REQ-032 SHALL place class encodings (FXU=0, LSU=1, BR=2, NOP=3), entry field offsets and ENTRY_W in shared package dispatch_pkg.
REQ-033 SHALL implement per-operand tag match and capture in sub-module operand_wakeup, instantiated per stored operand.

Verification
REQ-034 SHALL verify: four FXU entries enqueued, fxu_ready=2'b11 -> two dispatch on channels 0,1 in cycle N+1; remaining two in N+2.
REQ-035 SHALL verify: order FXU, BR, BR with br_ready=1 -> FXU and first BR dispatch; second BR waits one cycle.
REQ-036 SHALL verify: DEPTH=16 filled, free_slots=0, a 2-lane group is dropped; then 3 dispatched -> free_slots=3 next cycle; 40 entries pass across wrap in order.
REQ-037 SHALL verify: entry a_tag=5 invalid, bc lane1 tag 5 value 16'h1234 in its dispatch cycle -> output a_valid=1, a_value=16'h1234.
REQ-038 SHALL verify: flush with count=9 and enqueue active -> no outputs that cycle, count=0 next cycle; rst mid-dispatch -> out_valid=0 immediately.
